button_event_queue: RTL and testbench

BUTTON_EVENT_QUEUE -- requirements
Module: button_event_queue

---
 rtl/button_event_pkg.sv | 21 ++
 rtl/event_fifo.sv | 78 +++++++
 rtl/button_event_queue.sv | 113 +++++++++++
 tb/tb_button_event_queue.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/button_event_pkg.sv
// Shared defaults, types and helpers for the button event queue.
package button_event_pkg;

  localparam int N_BTN_DEF = 4;
  localparam int DEPTH_DEF = 8;
  localparam int DROP_MAX  = 255;

  // Button index carried by each queued event (sized for the default button count).
  typedef logic [$clog2(N_BTN_DEF)-1:0] evt_code_t;

  // Number of set bits in a byte; used to count simultaneous drops.
  function automatic logic [3:0] count_ones(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/event_fifo.sv
// Synchronous FIFO holding button codes. A push into a full FIFO is accepted
// only when a pop happens on the same edge; a pop from an empty FIFO is ignored.
module event_fifo
  import button_event_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full     = (count_q == (AW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  // Accepted operations, pointer advance (wrapping modulo DEPTH) and occupancy.
  always_comb begin
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset because occupancy gates visibility.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // Occupancy must stay within the physical depth.
  a_count_bound: assert property (@(posedge clock) disable iff (reset)
    count_q <= (AW+1)'(DEPTH));

endmodule

// File: rtl/button_event_queue.sv
// Collects one-cycle button pulses into pending bits, then feeds them one per
// edge (lowest index first) into an event FIFO drained by a consumer.
//
// Handshake: evt_valid is high exactly when the FIFO holds an entry and
// evt_code is the head entry; an event is consumed at a rising edge where
// evt_valid and evt_ready are both 1, and the head stays stable otherwise.
module button_event_queue
  import button_event_pkg::*;
#(
  parameter int N_BTN = N_BTN_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [N_BTN-1:0]           pulse,
  input  logic                       evt_ready,
  input  logic                       clear_ovf,
  output logic                       evt_valid,
  output logic [$clog2(N_BTN)-1:0]   evt_code,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic [7:0]                 drop_cnt
);

  localparam int CW = $clog2(N_BTN);

  logic [N_BTN-1:0] pending_q, pending_d;
  logic             overflow_q, overflow_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;

  logic             enq_valid;
  logic [CW-1:0]    enq_idx;
  logic [N_BTN-1:0] enq_mask;
  logic [N_BTN-1:0] drop_mask;
  logic [3:0]       n_drop;
  logic [7:0]       base_cnt;
  logic             base_ovf;
  logic [8:0]       drop_sum;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CW-1:0]    head_code;
  logic [$clog2(DEPTH):0] fifo_count;

  event_fifo #(
    .WIDTH (CW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (enq_idx),
    .pop       (pop),
    .pop_data  (head_code),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign evt_valid = ~fifo_empty;
  assign evt_code  = evt_valid ? head_code : '0;
  assign count     = fifo_count;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;

  // Arbiter: pick the lowest pending index and enqueue it when space exists
  // now or is freed by a pop on the same edge.
  always_comb begin
    enq_valid = 1'b0;
    enq_idx   = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        enq_valid = 1'b1;
        enq_idx   = CW'(i);
      end
    end
    pop      = evt_valid & evt_ready;
    push     = enq_valid & (~fifo_full | pop);
    enq_mask = push ? (N_BTN'(1) << enq_idx) : '0;
  end

  // Pending update and drop accounting. A pulse hitting a bit that stays
  // pending is lost; a pulse on the bit being enqueued simply re-arms it.
  always_comb begin
    pending_d  = (pending_q & ~enq_mask) | pulse;
    drop_mask  = pulse & pending_q & ~enq_mask;
    n_drop     = count_ones(8'(drop_mask));
    base_cnt   = clear_ovf ? 8'd0 : drop_cnt_q;
    base_ovf   = clear_ovf ? 1'b0 : overflow_q;
    drop_sum   = {1'b0, base_cnt} + {5'b00000, n_drop};
    overflow_d = base_ovf;
    drop_cnt_d = base_cnt;
    if (n_drop != 4'd0) begin
      overflow_d = 1'b1;
      drop_cnt_d = (drop_sum > 9'(DROP_MAX)) ? 8'(DROP_MAX) : drop_sum[7:0];
    end
  end

  // State registers; reset discards pending events and clears the drop record.
  always_ff @(posedge clock) begin
    if (reset) begin
      pending_q  <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

endmodule

// File: tb/tb_button_event_queue.sv
// Directed bench for button_event_queue with a queue-based reference model.
module tb_button_event_queue;

  localparam int N = 4;
  localparam int D = 8;

  logic                       clock = 1'b0;
  logic                       reset;
  logic [N-1:0]               pulse;
  logic                       evt_ready;
  logic                       clear_ovf;
  logic                       evt_valid;
  button_event_pkg::evt_code_t evt_code;
  logic [3:0]                 count;
  logic                       overflow;
  logic [7:0]                 drop_cnt;

  int checks   = 0;
  int failures = 0;

  // Reference model state: event queue, pending set, overflow record.
  int           mq[$];
  logic [N-1:0] m_pend;
  bit           m_ovf;
  int           m_drop;
  bit           model_ok = 1'b0;

  int           s[$];

  button_event_queue #(.N_BTN(N), .DEPTH(D)) dut (
    .clock     (clock),
    .reset     (reset),
    .pulse     (pulse),
    .evt_ready (evt_ready),
    .clear_ovf (clear_ovf),
    .evt_valid (evt_valid),
    .evt_code  (evt_code),
    .count     (count),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
  );

  // Clock.
  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Reference model, advanced on every rising edge from the sampled inputs.
  always @(posedge clock) begin
    if (reset) begin
      mq.delete();
      m_pend   = '0;
      m_ovf    = 1'b0;
      m_drop   = 0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      int lowest;
      int drops;
      if (mq.size() > 0 && evt_ready) void'(mq.pop_front());
      lowest = -1;
      for (int i = N - 1; i >= 0; i--) if (m_pend[i]) lowest = i;
      if (lowest >= 0 && mq.size() < D) begin
        mq.push_back(lowest);
        m_pend[lowest] = 1'b0;
      end
      drops = 0;
      for (int i = 0; i < N; i++) begin
        if (pulse[i]) begin
          if (m_pend[i]) drops++;
          m_pend[i] = 1'b1;
        end
      end
      if (clear_ovf) begin
        m_ovf  = 1'b0;
        m_drop = 0;
      end
      if (drops > 0) begin
        m_ovf  = 1'b1;
        m_drop = (m_drop + drops > 255) ? 255 : m_drop + drops;
      end
    end
  end

  // Scoreboard compare on every falling edge once the model is initialised.
  always @(negedge clock) begin
    if (model_ok) begin
      chk("cmp_valid",    int'(evt_valid), (mq.size() != 0) ? 1 : 0);
      chk("cmp_code",     int'(evt_code),  (mq.size() != 0) ? mq[0] : 0);
      chk("cmp_count",    int'(count),     mq.size());
      chk("cmp_overflow", int'(overflow),  int'(m_ovf));
      chk("cmp_drop_cnt", int'(drop_cnt),  m_drop);
      chk("cmp_pending",  int'(dut.pending_q), int'(m_pend));
    end
  end

  // Directed stimulus with hand-computed expectations.
  initial begin
    reset = 1'b1; pulse = '0; evt_ready = 1'b0; clear_ovf = 1'b0;
    cyc(); cyc();
    reset = 1'b0;
    chk("rst_valid", int'(evt_valid), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_code", int'(evt_code), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_drop_cnt", int'(drop_cnt), 0);

    // Single pulse latency with consumer ready.
    evt_ready = 1'b1; pulse = 4'b0010;
    cyc();
    pulse = '0;
    chk("lat_valid_k", int'(evt_valid), 0);
    cyc();
    chk("lat_valid_k1", int'(evt_valid), 1);
    chk("lat_code_k1", int'(evt_code), 1);
    chk("lat_count_k1", int'(count), 1);
    cyc();
    chk("lat_count_after_pop", int'(count), 0);
    chk("lat_valid_after_pop", int'(evt_valid), 0);

    // Simultaneous pulses enqueue in ascending order.
    evt_ready = 1'b0; pulse = 4'b1011;
    cyc();
    pulse = '0;
    cyc(); cyc(); cyc();
    chk("multi_count", int'(count), 3);
    chk("multi_overflow", int'(overflow), 0);
    chk("multi_code0", int'(evt_code), 0);
    evt_ready = 1'b1;
    cyc();
    chk("multi_code1", int'(evt_code), 1);
    cyc();
    chk("multi_code3", int'(evt_code), 3);
    cyc();
    evt_ready = 1'b0;
    chk("multi_drained", int'(count), 0);

    // Fill with button 2, then hold one pending and drop one.
    for (int k = 0; k < 10; k++) begin
      pulse = 4'b0100;
      cyc();
      pulse = '0;
      if (k < 9) begin
        cyc(); cyc();
      end
    end
    chk("full_count", int'(count), 8);
    chk("full_pending2", int'(dut.pending_q[2]), 1);
    chk("full_overflow", int'(overflow), 1);
    chk("full_drop_cnt", int'(drop_cnt), 1);
    cyc(); cyc();
    evt_ready = 1'b1;
    cyc();
    evt_ready = 1'b0;
    chk("full_swap_count", int'(count), 8);
    chk("full_swap_pending2", int'(dut.pending_q[2]), 0);
    cyc();
    chk("full_hold_count", int'(count), 8);
    evt_ready = 1'b1;
    for (int k = 0; k < 8; k++) cyc();
    evt_ready = 1'b0;
    chk("full_drained", int'(count), 0);

    // Full queue with continuous push/pop across pointer wrap.
    for (int r = 0; r < 2; r++) begin
      pulse = 4'b1111;
      cyc();
      pulse = '0;
      for (int k = 0; k < 4; k++) cyc();
    end
    chk("wrap_fill_count", int'(count), 8);
    pulse = 4'b0001;
    cyc();
    chk("wrap_prime_count", int'(count), 8);
    chk("wrap_prime_pending", int'(dut.pending_q), 1);
    s = '{0, 1, 2, 3, 0, 1, 2, 3, 0};
    for (int j = 0; j < 20; j++) s.push_back(j % 4);
    evt_ready = 1'b1;
    for (int j = 0; j < 20; j++) begin
      pulse = 4'(1 << (j % 4));
      cyc();
      chk("wrap_count", int'(count), 8);
      chk("wrap_code", int'(evt_code), s[j + 1]);
    end
    pulse = '0;
    for (int k = 0; k < 10; k++) cyc();
    evt_ready = 1'b0;
    chk("wrap_drained", int'(count), 0);

    // Drop counter saturation and clear behaviour.
    pulse = 4'b1111;
    for (int k = 0; k < 110; k++) cyc();
    pulse = '0;
    chk("sat_drop_cnt", int'(drop_cnt), 255);
    chk("sat_overflow", int'(overflow), 1);
    clear_ovf = 1'b1;
    cyc();
    clear_ovf = 1'b0;
    chk("clr_overflow", int'(overflow), 0);
    chk("clr_drop_cnt", int'(drop_cnt), 0);
    clear_ovf = 1'b1; pulse = 4'b0001;
    cyc();
    chk("clr_vs_drop_overflow", int'(overflow), 1);
    chk("clr_vs_drop_cnt", int'(drop_cnt), 1);
    pulse = '0;
    cyc();
    clear_ovf = 1'b0;
    chk("clr2_overflow", int'(overflow), 0);
    chk("clr2_drop_cnt", int'(drop_cnt), 0);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("mid_reset_count", int'(count), 0);

    // Reset mid-operation with stored and pending events, plus pulse and pop.
    pulse = 4'b1111;
    cyc();
    pulse = '0;
    for (int k = 0; k < 4; k++) cyc();
    pulse = 4'b0001;
    cyc();
    pulse = 4'b0100;
    cyc();
    pulse = '0;
    chk("pre_rst_count", int'(count), 5);
    chk("pre_rst_pending", int'(dut.pending_q), 4);
    reset = 1'b1; pulse = 4'b0010; evt_ready = 1'b1;
    cyc();
    reset = 1'b0; pulse = '0; evt_ready = 1'b0;
    chk("post_rst_valid", int'(evt_valid), 0);
    chk("post_rst_count", int'(count), 0);
    chk("post_rst_code", int'(evt_code), 0);
    chk("post_rst_pending", int'(dut.pending_q), 0);
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("post_rst_quiet", int'(evt_valid), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
